// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Shift-add MUL (low word) and restoring signed DIV/REM, one bit per cycle, start/done handshake.
module muldiv_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 4,
  parameter logic [CTRL_W-1:0]  CTRL_MUL = 3,
  parameter logic [CTRL_W-1:0]  CTRL_DIV = 4,
  parameter logic [CTRL_W-1:0]  CTRL_REM = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CTRL_W-1:0]   op_ctrl;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic                q_sign;
  logic                r_sign;
  logic                div_zero;
  logic                div_ovf;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   quo;

  logic                valid_ctrl;
  logic                accept;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_trial;
  logic [DATA_W:0]     rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   fin_result;

  assign valid_ctrl = (ctrl == CTRL_MUL) || (ctrl == CTRL_DIV) || (ctrl == CTRL_REM);
  assign accept     = start && valid_ctrl && (state != ST_CALC);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    abs_a = in1;
    abs_b = in2;
    if (ctrl != CTRL_MUL) begin
      if (in1[DATA_W-1]) abs_a = -in1;
      if (in2[DATA_W-1]) abs_b = -in2;
    end
  end

  // One iteration of each datapath; the FSM picks which registers consume it.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
    acc_next  = {mul_sum, acc[DATA_W-1:1]};
    rem_shift = (rem << 1) | {{DATA_W{1'b0}}, quo[DATA_W-1]};
    rem_trial = rem_shift - {1'b0, mag_b};
    rem_next  = rem_trial[DATA_W] ? rem_shift : rem_trial;
    quo_next  = {quo[DATA_W-2:0], ~rem_trial[DATA_W]};
  end

  always_comb begin
    fin_result = acc_next[DATA_W-1:0];
    if (op_ctrl == CTRL_DIV) begin
      if (div_zero)     fin_result = '1;
      else if (div_ovf) fin_result = MIN_NEG;
      else              fin_result = q_sign ? -quo_next : quo_next;
    end else if (op_ctrl == CTRL_REM) begin
      if (div_zero)     fin_result = r_sign ? -mag_a : mag_a;
      else if (div_ovf) fin_result = '0;
      else              fin_result = r_sign ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: datapath registers are reset too, so an aborted op leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_ctrl  <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            state    <= ST_CALC;
            busy     <= 1'b1;
            cnt      <= '0;
            op_ctrl  <= ctrl;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            q_sign   <= in1[DATA_W-1] ^ in2[DATA_W-1];
            r_sign   <= in1[DATA_W-1];
            div_zero <= (in2 == '0);
            div_ovf  <= (in1 == MIN_NEG) && (in2 == '1);
            acc      <= {{DATA_W{1'b0}}, abs_b};
            rem      <= '0;
            quo      <= abs_a;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin_result;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  localparam logic [3:0]  C_ADD = 4'd2;
  localparam logic [3:0]  C_MUL = 4'd3;
  localparam logic [3:0]  C_DIV = 4'd4;
  localparam logic [3:0]  C_REM = 4'd5;
  localparam logic [31:0] MINV  = 32'h8000_0000;
  localparam int          LAT   = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ctrl   (ctrl),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics written directly from the arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (c == C_MUL) return a * b;
    if (c == C_DIV) begin
      if (b == 0) return 32'hFFFF_FFFF;
      if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
      return sa / sb;
    end
    if (b == 0) return a;
    if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
    return sa % sb;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issues one op at the current negedge and watches the following 33 cycles.
  // Returns at the negedge of the done cycle so a caller may start back-to-back.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int poke_at);
    logic [31:0] exp_v;
    logic [31:0] held;
    int busy_n;
    int done_n;
    int done_cnt;
    int changes;
    exp_v    = ref_model(c, a, b);
    held     = result;
    busy_n   = 0;
    done_n   = 0;
    done_cnt = 0;
    changes  = 0;
    start = 1'b1;
    ctrl  = c;
    in1   = a;
    in2   = b;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        ctrl  = 4'($urandom);
        in1   = $urandom;
        in2   = $urandom;
      end
      if (poke_at != 0 && n == poke_at) begin
        start = 1'b1;
        ctrl  = C_MUL;
        in1   = $urandom;
        in2   = $urandom;
      end
      if (poke_at != 0 && n == poke_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n < LAT && result !== held) changes++;
    end
    check({tag, " latency"}, 32'(done_n), 32'(LAT));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(LAT - 1));
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " result_hold"}, 32'(changes), 32'd0);
    check({tag, " result"}, result, exp_v);
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    ctrl  = '0;
    in1   = '0;
    in2   = '0;
    idle(3);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    idle(2);

    run_op(C_MUL, 32'd7, 32'hFFFF_FFFD, "mul_neg", 0);
    check("plan mul value", result, 32'hFFFF_FFEB);
    idle(2);

    run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
    check("plan div value", result, 32'hFFFF_FFFD);
    run_op(C_REM, 32'hFFFF_FFF9, 32'd2, "rem_b2b", 0);
    check("plan rem value", result, 32'hFFFF_FFFF);
    idle(2);

    run_op(C_DIV, 32'd5, 32'd0, "div_zero", 0);
    run_op(C_REM, 32'd5, 32'd0, "rem_zero", 0);
    check("plan rem_zero value", result, 32'd5);
    run_op(C_DIV, MINV, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(C_REM, MINV, 32'hFFFF_FFFF, "rem_ovf", 0);
    idle(3);

    // Unsupported control code must not start anything.
    start = 1'b1;
    ctrl  = C_ADD;
    in1   = 32'd9;
    in2   = 32'd9;
    busy_seen = 0;
    done_seen = 0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
      @(negedge clk);
    end
    check("add_ignored busy", 32'(busy_seen), 32'd0);
    check("add_ignored done", 32'(done_seen), 32'd0);

    // A start during CALC must neither disturb the op nor queue a second one.
    run_op(C_MUL, 32'd3, 32'd4, "mul_poke", 10);
    check("plan mul_poke value", result, 32'd12);
    done_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mul_poke extra_done", 32'(done_seen), 32'd0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       rc = C_MUL;
        1:       rc = C_DIV;
        default: rc = C_REM;
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 15); end
        3: rb = 32'($signed(-$urandom_range(1, 15)));
        default: ;
      endcase
      run_op(rc, ra, rb, $sformatf("rand%0d", i), 0);
      idle($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a divide.
    idle(2);
    start = 1'b1;
    ctrl  = C_DIV;
    in1   = 32'd100;
    in2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    idle(14);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("abort no_busy", 32'(busy_seen), 32'd0);
    check("abort no_done", 32'(done_seen), 32'd0);

    run_op(C_DIV, 32'd100, 32'd7, "post_reset_div", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-cycle multiply/divide unit that sits beside the ALU in the execute stage. It takes the same operands and 4-bit ALU control code the ALU receives, and it accepts only the MUL, DIV and REM codes. While it is busy it stalls the pipeline. It returns the RV32M-compliant low-word product, the signed quotient or the signed remainder through a start/done handshake.

## Interface

Parameters:
- DATA_W, 32 — operand and result width; the iteration count equals DATA_W.
- CTRL_W, 4 — ALU control code width.
- CTRL_MUL, 3 — control code for multiply, low word.
- CTRL_DIV, 4 — control code for signed divide.
- CTRL_REM, 5 — control code for signed remainder.

Ports:
- clk  in  1  — single clock; all state is updated on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- start  in  1  — request a new operation; sampled on the clk edge.
- ctrl  in  CTRL_W  — ALU control code, sampled with start.
- in1  in  DATA_W  — multiplicand or dividend (rs1 data).
- in2  in  DATA_W  — multiplier or divisor (rs2 data).
- busy  out  1  — registered; high while an operation is in progress; the pipeline stall source.
- done  out  1  — registered; one-cycle pulse when result is valid.
- result  out  DATA_W  — registered; holds the last completed result until the next completion.

## Operation

- FSM with three states: IDLE, CALC, DONE. Reset state is IDLE.
- Accept condition: start=1 and ctrl ∈ {CTRL_MUL, CTRL_DIV, CTRL_REM}, while in IDLE or DONE.
  - start with any other ctrl is ignored: the FSM stays in IDLE and busy stays 0.
  - start in CALC is ignored; the latched operands are not disturbed.
- On accept:
  - Latch ctrl.
  - Latch operand magnitudes (absolute values for DIV/REM; raw values for MUL).
  - Latch the quotient sign (in1[31]^in2[31]) and the remainder sign (in1[31]).
  - Clear the 5-bit counter; go to CALC.
- CALC, MUL: shift-add, one multiplier bit per cycle. The product accumulator is 2*DATA_W wide; only the low DATA_W bits are returned. The low word is signedness-independent, so no sign fix-up is applied.
- CALC, DIV/REM: restoring division, one quotient bit per cycle on the magnitudes.
  - Remainder register is DATA_W+1 bits, so the trial subtract cannot overflow.
- On counter==DATA_W-1: go to DONE and write result.
  - DIV result: negate the quotient when the quotient sign is 1.
  - REM result: negate the remainder when the remainder sign is 1.
- Special cases; latency stays fixed at DATA_W+1 for these:
  - Divide by zero: DIV returns all-ones; REM returns in1 unchanged.
  - Overflow (in1=0x80000000, in2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Both cases are detected at accept and override the iterative result on the DONE write.
- DONE → IDLE on the next cycle, unless a new accept occurs (back-to-back start → CALC).

## Timing

- Reset values: busy=0, done=0, result=0, state=IDLE, counter=0, all datapath registers 0.
- Accept at edge T:
  - busy=1 from T+1 through T+32 (CALC, 32 cycles).
  - done=1 and result valid at T+33 (DONE); busy=0 in that cycle.
- Latency is DATA_W+1=33 cycles for every op. Back-to-back throughput is 1 op per 33 cycles.
- done is high for exactly one cycle per accepted op and is never asserted without a prior accept.
- result changes only on entry to DONE; it is stable at every other time.
- rst asserted mid-CALC aborts immediately (asynchronous). All outputs go to their reset values, and no done is issued for the aborted op.
- ctrl, in1 and in2 may change freely after the accept edge; the unit uses only latched copies.

## Test plan

- MUL: in1=7, in2=0xFFFFFFFD (−3), start at T → done at T+33, result=0xFFFFFFEB; busy=1 for T+1..T+32.
- DIV and REM signed, back-to-back: in1=0xFFFFFFF9 (−7), in2=2.
  - DIV → result=0xFFFFFFFD (−3).
  - Issue REM with start asserted in the DONE cycle → done 33 cycles later, result=0xFFFFFFFF (−1).
- Divide by zero: in1=5, in2=0.
  - DIV → 0xFFFFFFFF.
  - REM → 5.
  - Both at the standard 33-cycle latency.
- Overflow: in1=0x80000000, in2=0xFFFFFFFF.
  - DIV → 0x80000000.
  - REM → 0.
- Ignored starts, covering both ignore rules:
  - start with ctrl=2 (ADD) → busy stays 0 and no done.
  - Start MUL 3×4, then assert start with different operands at T+10 → only one done at T+33, result=12.
- Reset mid-op: start DIV 100/7, assert rst at T+15 → busy, done and result go to 0 immediately; after release, no done appears within 40 cycles.
